// File: rtl/freq_poll_pkg.sv
// Shared definitions for the freq counter poller: register map offsets,
// CTRL/STATUS bit positions, the FSM state encoding and an address helper.
package freq_poll_pkg;

    // Register byte offsets inside freq_counter_regs (BASE_ADDR is added on top)
    localparam logic [31:0] REG_HEADER0      = 32'h00;
    localparam logic [31:0] REG_STATUS       = 32'h10;
    localparam logic [31:0] REG_CTRL         = 32'h14;
    localparam logic [31:0] REG_SAMP_WIDTH   = 32'h18;
    localparam logic [31:0] REG_SAMP_COUNT_0 = 32'h20;
    localparam logic [31:0] REG_SAMP_COUNT_7 = 32'h3C;

    // CTRL and STATUS bit positions
    localparam int CTRL_RESETN_BIT       = 0;
    localparam int CTRL_SAMP_START_BIT   = 1;
    localparam int STATUS_SAMP_VALID_BIT = 0;

    // CTRL values written during a run
    localparam logic [31:0] CTRL_HOLD_RESET = 32'h0;
    localparam logic [31:0] CTRL_ARM        = 32'h1 << CTRL_RESETN_BIT;
    localparam logic [31:0] CTRL_GO         = CTRL_ARM | (32'h1 << CTRL_SAMP_START_BIT);

    // Measurement sequencer states
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR_RD,
        ST_WR_RST,
        ST_WR_WIDTH,
        ST_WR_ARM,
        ST_WR_GO,
        ST_GUARD,
        ST_POLL,
        ST_TO_WR,
        ST_RD_CNT,
        ST_PUSH,
        ST_DONE,
        ST_END_WR
    } state_t;

    // Offset of SAMP_COUNT_<idx>
    function automatic logic [31:0] count_offset(input logic [2:0] idx);
        return REG_SAMP_COUNT_0 + {27'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/freq_poll_timer.sv
// Loadable saturating down-counter. Shared between the post-start guard
// interval and the STATUS poll timeout; expired is high while the count is 0.
module freq_poll_timer #(
    parameter int W = 32
) (
    input  logic         sys_if_clk,
    input  logic         sys_if_rstn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt_q;

    // Load has priority; otherwise count down and stick at zero
    always_ff @(posedge sys_if_clk or negedge sys_if_rstn) begin
        if (!sys_if_rstn) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/freq_counter_poller.sv
// Bus initiator that runs freq counter measurements on the sys_if register
// interface and streams SAMP_COUNT_0..7 out over a valid/ready port.
// Optional feature macro: FREQ_POLL_HEADER_CHECK_EN (HEADER0 check before a run).
//
// Result handshake: a beat transfers on a clock edge where res_valid and
// res_ready are both 1; res_idx/res_data stay stable while res_valid=1 and
// res_ready=0, and res_valid never drops before the transfer.
//
// Bus outputs are registered from the next state, so while the FSM sits in a
// bus state the matching transaction is on sys_if_* for exactly that cycle.
module freq_counter_poller
    import freq_poll_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          GUARD_CYC   = 16,
    parameter int          TIMEOUT_CYC = 2**24,
    parameter logic [31:0] EXP_HEADER0 = 32'h0
) (
    input  logic        sys_if_clk,
    input  logic        sys_if_rstn,
    input  logic        cfg_start,
    input  logic        cfg_continuous,
    input  logic        cfg_stop,
    input  logic [31:0] cfg_samp_width,
    output logic        busy,
    output logic        done,
    output logic        err_timeout,
    output logic        err_header,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [2:0]  res_idx,
    output logic [31:0] res_data,
    output logic        sys_if_wen,
    output logic [31:0] sys_if_addr,
    output logic [31:0] sys_if_wdata,
    input  logic [31:0] sys_if_rdata,
    output state_t      dbg_state
);

    // Timer reload values: N cycles means loading N-1 (at least one cycle)
    localparam logic [31:0] GUARD_LOAD   = (GUARD_CYC   > 0) ? 32'(GUARD_CYC - 1)   : 32'd0;
    localparam logic [31:0] TIMEOUT_LOAD = (TIMEOUT_CYC > 0) ? 32'(TIMEOUT_CYC - 1) : 32'd0;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] hold_q;
    logic [31:0] width_q;
    logic        cont_q;
    logic        stop_pend_q;
    logic        err_to_q;
    logic        tmr_load;
    logic [31:0] tmr_val;
    logic        tmr_expired;
    logic        start_acc;
    logic        samp_valid;
    logic        hdr_ok;
    logic        wen_d;
    logic [31:0] addr_d, wdata_d;

    assign start_acc  = (state_q == ST_IDLE) && cfg_start;
    assign samp_valid = sys_if_rdata[STATUS_SAMP_VALID_BIT];

`ifdef FREQ_POLL_HEADER_CHECK_EN
    assign hdr_ok = (sys_if_rdata == EXP_HEADER0);
`else
    logic unused_hdr;
    assign unused_hdr = ^EXP_HEADER0;
    assign hdr_ok     = 1'b1;
`endif

    freq_poll_timer #(.W(32)) u_timer (
        .sys_if_clk  (sys_if_clk),
        .sys_if_rstn (sys_if_rstn),
        .load        (tmr_load),
        .load_val    (tmr_val),
        .expired     (tmr_expired)
    );

    // Next-state, timer load and index update
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            ST_IDLE: begin
                idx_d = 3'd0;
                if (cfg_start) begin
`ifdef FREQ_POLL_HEADER_CHECK_EN
                    state_d = ST_HDR_RD;
`else
                    state_d = ST_WR_RST;
`endif
                end
            end
            ST_HDR_RD:   state_d = hdr_ok ? ST_WR_RST : ST_IDLE;
            ST_WR_RST:   state_d = ST_WR_WIDTH;
            ST_WR_WIDTH: state_d = ST_WR_ARM;
            ST_WR_ARM:   state_d = ST_WR_GO;
            ST_WR_GO: begin
                state_d  = ST_GUARD;
                tmr_load = 1'b1;
                tmr_val  = GUARD_LOAD;
            end
            ST_GUARD: begin
                if (tmr_expired) begin
                    state_d  = ST_POLL;
                    tmr_load = 1'b1;
                    tmr_val  = TIMEOUT_LOAD;
                end
            end
            ST_POLL: begin
                if (samp_valid) begin
                    state_d = ST_RD_CNT;
                end else if (tmr_expired) begin
                    state_d = ST_TO_WR;
                end
            end
            ST_TO_WR:  state_d = ST_IDLE;
            ST_RD_CNT: state_d = ST_PUSH;
            ST_PUSH: begin
                if (res_ready) begin
                    idx_d   = idx_q + 3'd1;
                    state_d = (idx_q == 3'd7) ? ST_DONE : ST_RD_CNT;
                end
            end
            ST_DONE: begin
                if (cont_q && !stop_pend_q && !cfg_stop) begin
                    state_d = ST_WR_GO;
                end else begin
                    state_d = ST_END_WR;
                end
            end
            ST_END_WR: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Bus transaction to present while in the next state
    always_comb begin
        wen_d   = 1'b0;
        addr_d  = BASE_ADDR + REG_STATUS;
        wdata_d = '0;
        case (state_d)
            ST_HDR_RD:   addr_d = BASE_ADDR + REG_HEADER0;
            ST_WR_RST:   begin wen_d = 1'b1; addr_d = BASE_ADDR + REG_CTRL;       wdata_d = CTRL_HOLD_RESET; end
            ST_WR_WIDTH: begin wen_d = 1'b1; addr_d = BASE_ADDR + REG_SAMP_WIDTH; wdata_d = width_q;         end
            ST_WR_ARM:   begin wen_d = 1'b1; addr_d = BASE_ADDR + REG_CTRL;       wdata_d = CTRL_ARM;        end
            ST_WR_GO:    begin wen_d = 1'b1; addr_d = BASE_ADDR + REG_CTRL;       wdata_d = CTRL_GO;         end
            ST_TO_WR:    begin wen_d = 1'b1; addr_d = BASE_ADDR + REG_CTRL;       wdata_d = CTRL_HOLD_RESET; end
            ST_END_WR:   begin wen_d = 1'b1; addr_d = BASE_ADDR + REG_CTRL;       wdata_d = CTRL_ARM;        end
            ST_RD_CNT:   addr_d = BASE_ADDR + count_offset(idx_d);
            default:     ;
        endcase
    end

    // State, bus and index registers
    always_ff @(posedge sys_if_clk or negedge sys_if_rstn) begin
        if (!sys_if_rstn) begin
            state_q      <= ST_IDLE;
            idx_q        <= 3'd0;
            sys_if_wen   <= 1'b0;
            sys_if_addr  <= BASE_ADDR + REG_STATUS;
            sys_if_wdata <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            sys_if_wen   <= wen_d;
            sys_if_addr  <= addr_d;
            sys_if_wdata <= wdata_d;
        end
    end

    // Run configuration, result holding register, stop request and timeout flag
    always_ff @(posedge sys_if_clk or negedge sys_if_rstn) begin
        if (!sys_if_rstn) begin
            hold_q      <= '0;
            width_q     <= '0;
            cont_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            err_to_q    <= 1'b0;
        end else begin
            if (start_acc) begin
                width_q <= cfg_samp_width;
                cont_q  <= cfg_continuous;
            end
            if (state_q == ST_RD_CNT) begin
                hold_q <= sys_if_rdata;
            end
            if (state_q == ST_IDLE) begin
                stop_pend_q <= 1'b0;
            end else if (cfg_stop) begin
                stop_pend_q <= 1'b1;
            end
            if (start_acc) begin
                err_to_q <= 1'b0;
            end else if (state_q == ST_POLL && !samp_valid && tmr_expired) begin
                err_to_q <= 1'b1;
            end
        end
    end

`ifdef FREQ_POLL_HEADER_CHECK_EN
    logic err_hdr_q;

    // Sticky header mismatch flag, cleared by the next accepted start
    always_ff @(posedge sys_if_clk or negedge sys_if_rstn) begin
        if (!sys_if_rstn) begin
            err_hdr_q <= 1'b0;
        end else if (start_acc) begin
            err_hdr_q <= 1'b0;
        end else if (state_q == ST_HDR_RD && !hdr_ok) begin
            err_hdr_q <= 1'b1;
        end
    end

    assign err_header = err_hdr_q;
`else
    assign err_header = 1'b0;
`endif

    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign res_valid   = (state_q == ST_PUSH);
    assign res_idx     = idx_q;
    assign res_data    = hold_q;
    assign err_timeout = err_to_q;
    assign dbg_state   = state_q;

endmodule
